param_reg_block: RTL and testbench

PARAM_REG_BLOCK -- requirements
Module: param_reg_block

---
 rtl/param_reg_block.sv | 189 ++++++++++++++++++
 tb/tb_param_reg_block.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/param_reg_block.sv
// param_reg_block: byte-strobed register file plus a forwarded, handshaked memory window.
// Define REGBLK_TIMEOUT_EN to bound the memory wait with an error response after TIMEOUT_CYC cycles.
`timescale 1ns/1ps
module param_reg_block #(
  parameter int unsigned          DATA_W      = 32,
  parameter int unsigned          ADDR_W      = 8,
  parameter int unsigned          NUM_REGS    = 4,
  parameter logic [NUM_REGS-1:0]  RO_MASK     = '0,
  parameter logic [DATA_W-1:0]    RST_VAL     = '0,
  parameter int unsigned          MEM_BASE    = 'h20,
  parameter int unsigned          MEM_DEPTH   = 8,
  parameter int unsigned          TIMEOUT_CYC = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [ADDR_W-1:0]            bus_addr,
  input  logic                         bus_we,
  input  logic                         bus_re,
  input  logic [DATA_W-1:0]            bus_wdata,
  input  logic [DATA_W/8-1:0]          bus_wstrb,
  output logic [DATA_W-1:0]            bus_rdata,
  output logic                         bus_ready,
  output logic                         bus_err,
  output logic [NUM_REGS*DATA_W-1:0]   regs_q,
  output logic [ADDR_W-1:0]            mem_addr,
  output logic                         mem_we,
  output logic                         mem_re,
  output logic [DATA_W-1:0]            mem_wdata,
  output logic [DATA_W/8-1:0]          mem_wstrb,
  input  logic [DATA_W-1:0]            mem_rdata,
  input  logic                         mem_ready
);

  localparam int unsigned       BYTES      = DATA_W / 8;
  localparam int unsigned       LSB        = $clog2(BYTES);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(BYTES - 1);
  localparam logic [31:0]       REG_END    = 32'(NUM_REGS * BYTES);
  localparam logic [31:0]       WIN_LO     = 32'(MEM_BASE);
  localparam logic [31:0]       WIN_HI     = 32'(MEM_BASE + MEM_DEPTH * BYTES);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] RESP     = 2'd1;
  localparam logic [1:0] MEM_REQ  = 2'd2;
  localparam logic [1:0] MEM_WAIT = 2'd3;

  if (TIMEOUT_CYC == 0 || (DATA_W % 8) != 0) begin : g_bad_cfg
    $error("param_reg_block: TIMEOUT_CYC must be nonzero and DATA_W a multiple of 8");
  end

  logic [1:0]                state_q, state_d;
  logic [NUM_REGS*DATA_W-1:0] regs_d;
  logic [DATA_W-1:0]         rdata_q, rdata_d;
  logic                      err_q, err_d;
  logic                      op_we_q, op_we_d;
  logic [ADDR_W-1:0]         mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]         mem_wdata_q, mem_wdata_d;
  logic [BYTES-1:0]          mem_wstrb_q, mem_wstrb_d;

  logic [ADDR_W-1:0] addr_al, word_idx, win_off;
  logic [31:0]       addr_ext;
  logic              reg_hit, win_hit, conflict;

`ifdef REGBLK_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

  // Sub-word address bits are dropped before any decode.
  assign addr_al  = bus_addr & ALIGN_MASK;
  assign addr_ext = 32'(addr_al);
  assign word_idx = addr_al >> LSB;
  assign win_off  = (addr_al - ADDR_W'(MEM_BASE)) >> LSB;
  assign reg_hit  = addr_ext < REG_END;
  assign win_hit  = (addr_ext >= WIN_LO) && (addr_ext < WIN_HI) && !reg_hit;
  assign conflict = bus_we && bus_re;

  assign bus_rdata = rdata_q;
  assign bus_ready = (state_q == RESP);
  assign bus_err   = err_q && (state_q == RESP);
  assign mem_we    = (state_q == MEM_REQ) && op_we_q;
  assign mem_re    = (state_q == MEM_REQ) && !op_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_wstrb = mem_wstrb_q;

  always_comb begin
    state_d     = state_q;
    regs_d      = regs_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    op_we_d     = op_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wstrb_d = mem_wstrb_q;
`ifdef REGBLK_TIMEOUT_EN
    cnt_d       = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus_we || bus_re) begin
          if (!conflict && win_hit) begin
            state_d     = MEM_REQ;
            op_we_d     = bus_we;
            mem_addr_d  = win_off;
            mem_wdata_d = bus_wdata;
            mem_wstrb_d = bus_wstrb;
          end else begin
            // Errors and register writes answer with zero data.
            state_d = RESP;
            rdata_d = '0;
            err_d   = 1'b1;
            if (!conflict && reg_hit) begin
              err_d = 1'b0;
              for (int i = 0; i < NUM_REGS; i++) begin
                if (word_idx == ADDR_W'(i)) begin
                  if (bus_we) begin
                    if (RO_MASK[i]) begin
                      err_d = 1'b1;
                    end else begin
                      for (int b = 0; b < BYTES; b++) begin
                        if (bus_wstrb[b]) regs_d[i*DATA_W + b*8 +: 8] = bus_wdata[b*8 +: 8];
                      end
                    end
                  end else begin
                    rdata_d = regs_q[i*DATA_W +: DATA_W];
                  end
                end
              end
            end
          end
        end
      end
      RESP: state_d = IDLE;
      MEM_REQ: begin
        state_d = MEM_WAIT;
`ifdef REGBLK_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      MEM_WAIT: begin
        if (mem_ready) begin
          state_d = RESP;
          err_d   = 1'b0;
          rdata_d = op_we_q ? '0 : mem_rdata;
        end
`ifdef REGBLK_TIMEOUT_EN
        // A late mem_ready on the final counted cycle still wins above.
        else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
          state_d = RESP;
          err_d   = 1'b1;
          rdata_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      regs_q      <= {NUM_REGS{RST_VAL}};
      rdata_q     <= '0;
      err_q       <= 1'b0;
      op_we_q     <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wstrb_q <= '0;
`ifdef REGBLK_TIMEOUT_EN
      cnt_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      regs_q      <= regs_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      op_we_q     <= op_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wstrb_q <= mem_wstrb_d;
`ifdef REGBLK_TIMEOUT_EN
      cnt_q       <= cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_param_reg_block.sv
// Bench for param_reg_block: two instances (plain, and read-only reg 1 with nonzero reset value)
// share the stimulus; a transaction-level model predicts every output on every cycle.
`timescale 1ns/1ps
module tb_param_reg_block;

  localparam logic [31:0] RSTB = 32'h1234_5678;
`ifdef REGBLK_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [7:0]  bus_addr = '0;
  logic        bus_we = 1'b0, bus_re = 1'b0;
  logic [31:0] bus_wdata = '0;
  logic [3:0]  bus_wstrb = '0;
  logic [31:0] mem_rdata = '0;
  logic        mem_ready = 1'b0;

  logic [31:0]  bus_rdata_a, bus_rdata_b, mem_wdata_a, mem_wdata_b;
  logic         bus_ready_a, bus_ready_b, bus_err_a, bus_err_b;
  logic         mem_we_a, mem_we_b, mem_re_a, mem_re_b;
  logic [127:0] regs_a, regs_b;
  logic [7:0]   mem_addr_a, mem_addr_b;
  logic [3:0]   mem_wstrb_a, mem_wstrb_b;

  param_reg_block #(.DATA_W(32), .ADDR_W(8), .NUM_REGS(4), .RO_MASK(4'b0000), .RST_VAL(32'h0),
                    .MEM_BASE('h20), .MEM_DEPTH(8), .TIMEOUT_CYC(16)) u_a (
    .clk(clk), .rst(rst), .bus_addr(bus_addr), .bus_we(bus_we), .bus_re(bus_re),
    .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb), .bus_rdata(bus_rdata_a), .bus_ready(bus_ready_a),
    .bus_err(bus_err_a), .regs_q(regs_a), .mem_addr(mem_addr_a), .mem_we(mem_we_a), .mem_re(mem_re_a),
    .mem_wdata(mem_wdata_a), .mem_wstrb(mem_wstrb_a), .mem_rdata(mem_rdata), .mem_ready(mem_ready));

  param_reg_block #(.DATA_W(32), .ADDR_W(8), .NUM_REGS(4), .RO_MASK(4'b0010), .RST_VAL(RSTB),
                    .MEM_BASE('h20), .MEM_DEPTH(8), .TIMEOUT_CYC(16)) u_b (
    .clk(clk), .rst(rst), .bus_addr(bus_addr), .bus_we(bus_we), .bus_re(bus_re),
    .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb), .bus_rdata(bus_rdata_b), .bus_ready(bus_ready_b),
    .bus_err(bus_err_b), .regs_q(regs_b), .mem_addr(mem_addr_b), .mem_we(mem_we_b), .mem_re(mem_re_b),
    .mem_wdata(mem_wdata_b), .mem_wstrb(mem_wstrb_b), .mem_rdata(mem_rdata), .mem_ready(mem_ready));

  // Model state: register contents and the output values expected in the current cycle.
  logic [31:0] m_a [4];
  logic [31:0] m_b [4];
  logic [31:0] exp_rd_a, exp_rd_b, exp_mwdata;
  logic        exp_ready, exp_err_a, exp_err_b, exp_we, exp_re;
  logic [7:0]  exp_maddr;
  logic [3:0]  exp_mwstrb;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  task automatic reset_model();
    for (int i = 0; i < 4; i++) begin
      m_a[i] = 32'h0;
      m_b[i] = RSTB;
    end
    exp_rd_a = '0; exp_rd_b = '0; exp_mwdata = '0;
    exp_ready = 1'b0; exp_err_a = 1'b0; exp_err_b = 1'b0;
    exp_we = 1'b0; exp_re = 1'b0; exp_maddr = '0; exp_mwstrb = '0;
  endtask

  always @(negedge clk) begin
    chk("ready_a", 128'(bus_ready_a), 128'(exp_ready));
    chk("ready_b", 128'(bus_ready_b), 128'(exp_ready));
    chk("err_a", 128'(bus_err_a), 128'(exp_err_a));
    chk("err_b", 128'(bus_err_b), 128'(exp_err_b));
    chk("rdata_a", 128'(bus_rdata_a), 128'(exp_rd_a));
    chk("rdata_b", 128'(bus_rdata_b), 128'(exp_rd_b));
    chk("regs_a", regs_a, {m_a[3], m_a[2], m_a[1], m_a[0]});
    chk("regs_b", regs_b, {m_b[3], m_b[2], m_b[1], m_b[0]});
    chk("mem_we", 128'({mem_we_a, mem_we_b}), 128'({exp_we, exp_we}));
    chk("mem_re", 128'({mem_re_a, mem_re_b}), 128'({exp_re, exp_re}));
    chk("mem_addr", 128'({mem_addr_a, mem_addr_b}), 128'({exp_maddr, exp_maddr}));
    chk("mem_wdata", 128'({mem_wdata_a, mem_wdata_b}), 128'({exp_mwdata, exp_mwdata}));
    chk("mem_wstrb", 128'({mem_wstrb_a, mem_wstrb_b}), 128'({exp_mwstrb, exp_mwstrb}));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One bus request issued in an IDLE cycle; lat = wait cycle carrying mem_ready (0 = never),
  // abort_k = wait cycle in which reset is asserted instead (0 = none).
  task automatic xact(input logic we, input logic re, input logic [7:0] addr, input logic [31:0] wd,
                      input logic [3:0] ws, input int lat, input logic [31:0] mrd, input bit junk,
                      input int abort_k, output logic [31:0] rd_a, output logic [31:0] rd_b,
                      output logic e_a, output logic e_b, output logic [7:0] ma, output logic [31:0] mw);
    logic [7:0] al;
    int idx;
    bit regh, win, tout;
    al = addr & 8'hFC;
    idx = int'(al >> 2);
    regh = (al < 8'h10);
    win = (al >= 8'h20) && (al < 8'h40);
    tout = 1'b0;
    rd_a = '0; rd_b = '0; e_a = 1'b0; e_b = 1'b0; ma = '0; mw = '0;
    bus_we = we; bus_re = re; bus_addr = addr; bus_wdata = wd; bus_wstrb = ws;
    mem_ready = 1'($urandom_range(0, 1)); mem_rdata = $urandom;
    tick();
    bus_we = junk; bus_re = 1'b0; bus_addr = 8'h00; bus_wdata = $urandom; bus_wstrb = 4'hF;
    mem_ready = 1'($urandom_range(0, 1));
    if (win && !(we && re)) begin
      exp_we = we; exp_re = re; exp_maddr = (al - 8'h20) >> 2; exp_mwdata = wd; exp_mwstrb = ws;
      @(negedge clk);
      ma = mem_addr_a; mw = mem_wdata_a;
      for (int k = 1; k <= 64; k++) begin
        tick();
        exp_we = 1'b0; exp_re = 1'b0;
        if (k == abort_k) begin
          rst = 1'b1;
          reset_model();
          bus_we = 1'b0; mem_ready = 1'b0;
          return;
        end
        bus_we = junk & 1'($urandom_range(0, 1)); bus_re = junk & 1'($urandom_range(0, 1));
        bus_addr = 8'($urandom_range(0, 255));
        mem_ready = (k == lat);
        mem_rdata = (k == lat) ? mrd : $urandom;
        if (k == lat) break;
        if (TO_EN && k == 16) begin
          tout = 1'b1;
          break;
        end
      end
      tick();
      bus_we = junk; bus_re = 1'b0; bus_addr = 8'h00; mem_ready = 1'($urandom_range(0, 1));
      exp_ready = 1'b1; exp_err_a = tout; exp_err_b = tout;
      exp_rd_a = (tout || we) ? 32'h0 : mrd;
      exp_rd_b = exp_rd_a;
    end else begin
      exp_ready = 1'b1;
      exp_err_a = 1'b1; exp_err_b = 1'b1; exp_rd_a = '0; exp_rd_b = '0;
      if (!(we && re) && regh) begin
        exp_err_a = 1'b0; exp_err_b = 1'b0;
        if (we) begin
          for (int b = 0; b < 4; b++) begin
            if (ws[b]) begin
              m_a[idx][b*8 +: 8] = wd[b*8 +: 8];
              if (idx != 1) m_b[idx][b*8 +: 8] = wd[b*8 +: 8];
            end
          end
          if (idx == 1) exp_err_b = 1'b1;
        end else begin
          exp_rd_a = m_a[idx]; exp_rd_b = m_b[idx];
        end
      end
    end
    @(negedge clk);
    rd_a = bus_rdata_a; rd_b = bus_rdata_b; e_a = bus_err_a; e_b = bus_err_b;
    tick();
    bus_we = 1'b0; bus_re = 1'b0; mem_ready = 1'b0;
    exp_ready = 1'b0; exp_err_a = 1'b0; exp_err_b = 1'b0;
  endtask

  initial begin
    logic [31:0] ra, rb, mw;
    logic ea, eb;
    logic [7:0] ma, ad;
    int op, sel;
    reset_model();
    #1 rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;

    // Register write with partial strobes, then read-back; reg 1 is read-only in u_b.
    xact(1, 0, 8'h04, 32'hDEADBEEF, 4'b0011, 0, 0, 1, 0, ra, rb, ea, eb, ma, mw);
    chk("wr4_err_a", 128'(ea), 128'(1'b0));
    chk("wr4_err_b_ro", 128'(eb), 128'(1'b1));
    xact(0, 1, 8'h04, 32'h0, 4'h0, 0, 0, 0, 0, ra, rb, ea, eb, ma, mw);
    chk("rd4_a", 128'(ra), 128'(32'h0000BEEF));
    chk("rd4_b_unchanged", 128'(rb), 128'(RSTB));
    chk("rd4_err_a", 128'(ea), 128'(1'b0));
    chk("regs_b_r1", 128'(regs_b[63:32]), 128'(RSTB));
    // Unmapped read.
    xact(0, 1, 8'h80, 32'h0, 4'h0, 0, 0, 0, 0, ra, rb, ea, eb, ma, mw);
    chk("unmapped_err", 128'(ea), 128'(1'b1));
    chk("unmapped_rdata", 128'(ra), 128'(32'h0));
    // Window write, ready two cycles after the strobe.
    xact(1, 0, 8'h28, 32'hCAFEFEED, 4'hF, 2, 0, 0, 0, ra, rb, ea, eb, ma, mw);
    chk("win_wr_maddr", 128'(ma), 128'(8'd2));
    chk("win_wr_mwdata", 128'(mw), 128'(32'hCAFEFEED));
    chk("win_wr_err", 128'(ea), 128'(1'b0));
    // Window read with stray request pulses during the wait.
    xact(0, 1, 8'h20, 32'h0, 4'h0, 3, 32'h0BADC0DE, 1, 0, ra, rb, ea, eb, ma, mw);
    chk("win_rd_data", 128'(ra), 128'(32'h0BADC0DE));
    chk("win_rd_maddr", 128'(ma), 128'(8'd0));
`ifdef REGBLK_TIMEOUT_EN
    xact(0, 1, 8'h3C, 32'h0, 4'h0, 0, 32'h11111111, 0, 0, ra, rb, ea, eb, ma, mw);
    chk("timeout_err", 128'(ea), 128'(1'b1));
    chk("timeout_rdata", 128'(ra), 128'(32'h0));
    xact(0, 1, 8'h3C, 32'h0, 4'h0, 16, 32'h22222222, 0, 0, ra, rb, ea, eb, ma, mw);
    chk("ready_at_limit_err", 128'(ea), 128'(1'b0));
    chk("ready_at_limit_data", 128'(ra), 128'(32'h22222222));
`else
    xact(0, 1, 8'h3C, 32'h0, 4'h0, 20, 32'h22222222, 0, 0, ra, rb, ea, eb, ma, mw);
    chk("long_wait_err", 128'(ea), 128'(1'b0));
    chk("long_wait_data", 128'(ra), 128'(32'h22222222));
`endif

    // Randomized traffic.
    for (int n = 0; n < 250; n++) begin
      sel = $urandom_range(0, 3);
      case (sel)
        0: ad = 8'($urandom_range(0, 15));
        1: ad = 8'($urandom_range(8'h20, 8'h3F));
        2: ad = $urandom_range(0, 1) ? 8'($urandom_range(8'h10, 8'h1F)) : 8'($urandom_range(8'h40, 8'hFF));
        default: ad = 8'($urandom_range(0, 255));
      endcase
      op = $urandom_range(0, 9);
      xact(op == 0 || (op >= 1 && op <= 4), op == 0 || op >= 5, ad, $urandom, 4'($urandom_range(0, 15)),
           $urandom_range(1, 5), $urandom, 1'($urandom_range(0, 1)), 0, ra, rb, ea, eb, ma, mw);
      repeat ($urandom_range(0, 2)) begin
        mem_ready = 1'($urandom_range(0, 1));
        tick();
      end
      mem_ready = 1'b0;
    end

    // Make sure reset has something to clear, then reset in the middle of a memory wait.
    xact(1, 0, 8'h00, 32'hA5A5A5A5, 4'hF, 0, 0, 0, 0, ra, rb, ea, eb, ma, mw);
    xact(0, 1, 8'h24, 32'h0, 4'h0, 99, 0, 0, 2, ra, rb, ea, eb, ma, mw);
    #2;
    chk("rst_async_mem_re", 128'(mem_re_a), 128'(1'b0));
    chk("rst_async_regs_a", regs_a, 128'(0));
    chk("rst_async_regs_b", regs_b, {4{RSTB}});
    bus_re = 1'b1; bus_addr = 8'h04;
    tick();
    tick();
    bus_re = 1'b0;
    rst = 1'b0;
    xact(0, 1, 8'h04, 32'h0, 4'h0, 0, 0, 0, 0, ra, rb, ea, eb, ma, mw);
    chk("post_rst_rd_a", 128'(ra), 128'(32'h0));
    chk("post_rst_rd_b", 128'(rb), 128'(RSTB));
    chk("post_rst_err", 128'(ea), 128'(1'b0));
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
